// File: rtl/prog_mem_rw_if.sv
// prog_mem_rw_if: load/fetch bus of the writable program memory.
//   master : loader/decoder side (drives requests, clr, lock)
//   slave  : memory side (drives ld_ready, rd_data, rd_valid, busy)
// Signals:
//   clr       soft clear request (re-runs the NOP fill)
//   lock      write-protect level, blocks load handshakes
//   ld_valid / ld_ready / ld_addr / ld_data   load port (valid/ready)
//   rd_en / rd_addr / rd_data / rd_valid      fetch port (1-cycle latency)
//   busy      high while the fill sequence runs
interface prog_mem_rw_if #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic                  clr;
    logic                  lock;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  busy;

    modport master (
        output clr, lock, ld_valid, ld_addr, ld_data, rd_en, rd_addr,
        input  ld_ready, rd_data, rd_valid, busy
    );

    modport slave (
        input  clr, lock, ld_valid, ld_addr, ld_data, rd_en, rd_addr,
        output ld_ready, rd_data, rd_valid, busy
    );
endinterface

// File: rtl/prog_mem_rw.sv
// prog_mem_rw: writable program memory for the instruction fetch path.
// After reset (or a clr in RUN) every word is filled with NOP_WORD, one
// address per cycle, then the block accepts loads and serves fetches.
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    prog_mem_rw_if slave modport (load port, fetch port, clr,
//          lock, busy)
module prog_mem_rw #(
    parameter int unsigned           DATA_WIDTH = 6,
    parameter int unsigned           ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 6'b101000
) (
    input  logic           clk,
    input  logic           rst_n,
    prog_mem_rw_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ld_ready;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, write-port mux and handshake
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ld_ready = 1'b0;
        we       = 1'b0;
        waddr    = bus.ld_addr;
        wdata    = bus.ld_data;
        unique case (state_q)
            INIT: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = NOP_WORD;
                // counter wraps to 0 naturally on the last fill address
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ld_ready = !bus.lock && !bus.clr;
                we       = bus.ld_valid && ld_ready;
                if (bus.clr) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Array has no reset; contents are defined by the fill or by loads
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Fetch port; reading here with <= gives read-first on a same-address
    // load in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= NOP_WORD;
            rd_valid_q <= 1'b0;
        end else if (state_q == RUN && bus.rd_en) begin
            rd_data_q  <= mem[bus.rd_addr];
            rd_valid_q <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
        end
    end

    assign bus.ld_ready = ld_ready;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = (state_q == INIT);
endmodule

// File: tb/tb_prog_mem_rw.sv
// tb_prog_mem_rw: directed and random stimulus for prog_mem_rw, checked
// against a word-array reference that tracks the remaining fill cycles.
module tb_prog_mem_rw;
    localparam int unsigned DW    = 6;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;
    localparam logic [DW-1:0] NOP = 6'b101000;

    logic clk;
    logic rst_n;

    prog_mem_rw_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    prog_mem_rw #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NOP_WORD  (NOP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [DW-1:0] mem_m [DEPTH];
    int            init_left;
    logic [DW-1:0] exp_rd;
    logic          exp_rv;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.clr      = 1'b0;
        bus.lock     = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_data  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
    endtask

    task automatic model_reset();
        init_left = DEPTH;
        exp_rd    = NOP;
        exp_rv    = 1'b0;
    endtask

    // One clock with the current inputs: check ld_ready before the edge,
    // advance the model, then check the registered outputs after it.
    task automatic cycle();
        logic rdy;
        #1;
        rdy = (init_left == 0) && !bus.lock && !bus.clr;
        chk("ld_ready", {31'b0, bus.ld_ready}, {31'b0, rdy});
        if (init_left > 0) begin
            mem_m[DEPTH - init_left] = NOP;
            init_left--;
            exp_rv = 1'b0;
        end else begin
            if (bus.rd_en) begin
                exp_rd = mem_m[bus.rd_addr];
                exp_rv = 1'b1;
            end else begin
                exp_rv = 1'b0;
            end
            if (bus.ld_valid && rdy) mem_m[bus.ld_addr] = bus.ld_data;
            if (bus.clr) init_left = DEPTH;
        end
        @(posedge clk);
        #1;
        chk("busy", {31'b0, bus.busy}, {31'b0, (init_left > 0)});
        chk("rd_valid", {31'b0, bus.rd_valid}, {31'b0, exp_rv});
        chk("rd_data", {26'b0, bus.rd_data}, {26'b0, exp_rd});
    endtask

    task automatic fetch(input logic [AW-1:0] a);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        cycle();
        bus.rd_en   = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        cycle();
        bus.ld_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, bus.busy}, 32'd1);
        chk("rst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        chk("rst_rd_data", {26'b0, bus.rd_data}, {26'b0, NOP});
        chk("rst_ld_ready", {31'b0, bus.ld_ready}, 32'd0);
        rst_n = 1'b1;

        // Fill with no requests: busy through edge 31, low after edge 32
        for (int i = 1; i <= 32; i++) begin
            cycle();
            if (i == 31) chk("busy_edge31", {31'b0, bus.busy}, 32'd1);
        end
        chk("busy_edge32", {31'b0, bus.busy}, 32'd0);

        fetch(5'd0);
        chk("fetch0_nop", {26'b0, bus.rd_data}, {26'b0, NOP});
        cycle();
        chk("rd_valid_pulse", {31'b0, bus.rd_valid}, 32'd0);
        fetch(5'd17);
        fetch(5'd31);
        chk("fetch31_nop", {26'b0, bus.rd_data}, {26'b0, NOP});
        cycle();

        // Loads with valid held across addresses
        bus.ld_valid = 1'b1;
        bus.ld_addr = 5'd0; bus.ld_data = 6'b111000; cycle();
        bus.ld_addr = 5'd1; bus.ld_data = 6'b010110; cycle();
        bus.ld_addr = 5'd5; bus.ld_data = 6'b111111; cycle();
        bus.ld_valid = 1'b0;
        fetch(5'd0);
        chk("fetch0_loaded", {26'b0, bus.rd_data}, 32'h38);
        fetch(5'd1);
        fetch(5'd5);
        chk("fetch5_loaded", {26'b0, bus.rd_data}, 32'h3f);
        fetch(5'd2);
        chk("fetch2_nop", {26'b0, bus.rd_data}, {26'b0, NOP});

        // Locked load stays pending
        bus.lock = 1'b1;
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd3; bus.ld_data = 6'b000001;
        fetch(5'd3);
        chk("locked_fetch3", {26'b0, bus.rd_data}, {26'b0, NOP});
        cycle();
        bus.lock = 1'b0;
        cycle();
        bus.ld_valid = 1'b0;
        fetch(5'd3);
        chk("unlocked_fetch3", {26'b0, bus.rd_data}, 32'h01);

        // Same-cycle load and fetch: read-first
        bus.ld_valid = 1'b1; bus.ld_addr = 5'd4; bus.ld_data = 6'b010101;
        fetch(5'd4);
        bus.ld_valid = 1'b0;
        chk("rdw_old", {26'b0, bus.rd_data}, {26'b0, NOP});
        fetch(5'd4);
        chk("rdw_new", {26'b0, bus.rd_data}, 32'h15);

        // CLR pulse, with requests ignored during the refill
        load(5'd0, 6'b111000);
        bus.clr = 1'b1;
        cycle();
        bus.clr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.rd_en    = 1'($urandom_range(0, 1));
            bus.rd_addr  = 5'($urandom);
            bus.ld_valid = 1'($urandom_range(0, 1));
            bus.ld_addr  = 5'($urandom);
            bus.ld_data  = 6'($urandom);
            bus.clr      = 1'($urandom_range(0, 1));
            cycle();
        end
        idle_inputs();
        chk("clr_busy_done", {31'b0, bus.busy}, 32'd0);
        fetch(5'd0);
        chk("clr_fetch0_nop", {26'b0, bus.rd_data}, {26'b0, NOP});

        // Reset during fill cycle 10
        bus.clr = 1'b1;
        cycle();
        bus.clr = 1'b0;
        repeat (10) cycle();
        bus.rd_en = 1'b1;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_rd_valid", {31'b0, bus.rd_valid}, 32'd0);
        chk("midrst_busy", {31'b0, bus.busy}, 32'd1);
        chk("midrst_rd_data", {26'b0, bus.rd_data}, {26'b0, NOP});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.rd_en = 1'b0;
        repeat (31) cycle();
        chk("rerst_busy31", {31'b0, bus.busy}, 32'd1);
        cycle();
        chk("rerst_busy32", {31'b0, bus.busy}, 32'd0);

        // Random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            bus.lock     = ($urandom_range(0, 3) == 0);
            bus.clr      = ($urandom_range(0, 49) == 0);
            bus.ld_valid = 1'($urandom_range(0, 1));
            bus.ld_addr  = 5'($urandom);
            bus.ld_data  = 6'($urandom);
            bus.rd_en    = ($urandom_range(0, 9) < 6);
            bus.rd_addr  = ($urandom_range(0, 1) == 1) ? bus.ld_addr : 5'($urandom);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
